vga_sync_decoder: RTL and testbench

VGA_SYNC_DECODER -- requirements
Module: vga_sync_decoder

---
 rtl/vga_timing_pkg.sv | 23 ++
 rtl/sync_edge_detect.sv | 28 ++
 rtl/vga_sync_decoder.sv | 175 +++++++++++++++++
 tb/tb_vga_sync_decoder.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA 640x480 timing constants and the lock-state type used by the
// sync decoder (and by the matching generator).
package vga_timing_pkg;

    localparam int VGA_H_TOTAL = 800;
    localparam int VGA_V_TOTAL = 521;
    localparam int VGA_H_PULSE = 96;
    localparam int VGA_V_PULSE = 2;
    localparam int VGA_HBP     = 144;
    localparam int VGA_HFP     = 784;
    localparam int VGA_VBP     = 31;
    localparam int VGA_VFP     = 511;

    // Clocks without an h_sync fall before the decoder declares loss of sync.
    localparam int VGA_WD_LIMIT = 1024;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2
    } lock_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Registers one sync input (S1) and flags its falling and rising edges by
// comparing S1 with its previous value. Both stages idle high.
module sync_edge_detect (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_fall,
    output logic o_rise
);

    logic r_s1;
    logic r_prev;

    // S1 capture and one cycle of history
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1   <= 1'b1;
            r_prev <= 1'b1;
        end else begin
            r_s1   <= i_d;
            r_prev <= r_s1;
        end
    end

    assign o_fall = r_prev & ~r_s1;
    assign o_rise = ~r_prev & r_s1;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers pixel coordinates and colour from a VGA sync/RGB stream, tracks
// lock, counts frames, sums each frame's pixels and captures a probe pixel.
module vga_sync_decoder
    import vga_timing_pkg::*;
#(
    parameter int H_TOTAL = VGA_H_TOTAL,
    parameter int V_TOTAL = VGA_V_TOTAL,
    parameter int H_PULSE = VGA_H_PULSE,
    parameter int V_PULSE = VGA_V_PULSE,
    parameter int HBP     = VGA_HBP,
    parameter int HFP     = VGA_HFP,
    parameter int VBP     = VGA_VBP,
    parameter int VFP     = VGA_VFP
) (
    input  logic        vga_clk,
    input  logic        rst,
    input  logic        h_sync,
    input  logic        v_sync,
    input  logic [3:0]  v_red,
    input  logic [3:0]  v_green,
    input  logic [3:0]  v_blue,
    input  logic [9:0]  probe_x,
    input  logic [8:0]  probe_y,
    input  logic        err_clr,
    output logic [9:0]  pixel_x,
    output logic [8:0]  pixel_y,
    output logic        pixel_valid,
    output logic [11:0] pixel_rgb,
    output logic        frame_start,
    output logic        locked,
    output logic [7:0]  frame_cnt,
    output logic [15:0] frame_sum,
    output logic [11:0] probe_rgb,
    output logic        err_hline,
    output logic        err_hpulse,
    output logic        err_vframe,
    output logic        err_nosync
);

    logic        w_hfall, w_hrise, w_vfall, w_vrise;
    logic [11:0] r_rgb_s1, r_rgb_s2;
    logic [9:0]  r_hpos, r_vpos, r_wd;
    logic [9:0]  w_vpos_nxt;
    logic        r_vpend, r_hfirst, r_vfirst, r_frame_err;
    logic        w_vload, w_valid, w_wd_fire, w_to_unl;
    logic        w_hline_set, w_hpulse_set, w_vframe_set, w_err_evt;
    lock_state_t r_state, w_state_nxt;

    sync_edge_detect u_hs (.i_clk(vga_clk), .i_rst(rst), .i_d(h_sync), .o_fall(w_hfall), .o_rise(w_hrise));
    sync_edge_detect u_vs (.i_clk(vga_clk), .i_rst(rst), .i_d(v_sync), .o_fall(w_vfall), .o_rise(w_vrise));

    // A v_sync fall (pending or simultaneous) is consumed by the next h_sync fall.
    assign w_vload    = w_hfall & (r_vpend | w_vfall);
    assign w_vpos_nxt = w_vload ? 10'd0 :
                        (w_hfall && r_vpos != 10'h3FF) ? r_vpos + 10'd1 : r_vpos;

    // Edges are seen one clock before the position counter advances, so the
    // length checks use the count including the current clock.
    assign w_hline_set  = w_hfall & ~r_hfirst & (int'(r_hpos) + 1 != H_TOTAL);
    assign w_hpulse_set = w_hrise & ~r_hfirst & (int'(r_hpos) + 1 != H_PULSE);
    assign w_vframe_set = ~r_vfirst & ((w_vfall & (int'(r_vpos) + 1 != V_TOTAL)) |
                                       (w_vrise & (int'(w_vpos_nxt) != V_PULSE)));
    assign w_wd_fire    = (int'(r_wd) == VGA_WD_LIMIT - 1) & ~w_hfall;
    assign w_err_evt    = w_hline_set | w_hpulse_set | w_vframe_set | w_wd_fire;
    assign w_to_unl     = w_wd_fire | ((w_state_nxt == ST_UNLOCKED) && (r_state != ST_UNLOCKED));

    assign w_valid = (int'(r_hpos) >= HBP) && (int'(r_hpos) < HFP) &&
                     (int'(r_vpos) >= VBP) && (int'(r_vpos) < VFP);
    assign locked  = (r_state == ST_LOCKED);

    // Lock FSM next-state; the watchdog overrides everything
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_UNLOCKED: if (w_vfall) w_state_nxt = ST_ACQUIRE;
            ST_ACQUIRE:  if (w_vfall && !r_frame_err && !w_err_evt) w_state_nxt = ST_LOCKED;
            ST_LOCKED:   if (w_err_evt) w_state_nxt = ST_UNLOCKED;
            default:     w_state_nxt = ST_UNLOCKED;
        endcase
        if (w_wd_fire) w_state_nxt = ST_UNLOCKED;
    end

    // Lock state, per-frame error memory and post-unlock check exemptions
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_UNLOCKED;
            r_frame_err <= 1'b0;
            r_hfirst    <= 1'b1;
            r_vfirst    <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_err <= w_vfall ? 1'b0 : (r_frame_err | w_err_evt);
            if (w_to_unl)     r_hfirst <= 1'b1;
            else if (w_hfall) r_hfirst <= 1'b0;
            if (w_to_unl)     r_vfirst <= 1'b1;
            else if (w_vfall) r_vfirst <= 1'b0;
        end
    end

    // S1/S2 colour pipeline, position counters and watchdog
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_rgb_s1 <= '0;
            r_rgb_s2 <= '0;
            r_hpos   <= '0;
            r_vpos   <= '0;
            r_vpend  <= 1'b0;
            r_wd     <= '0;
        end else begin
            r_rgb_s1 <= {v_red, v_green, v_blue};
            r_rgb_s2 <= r_rgb_s1;
            if (w_hfall)                r_hpos <= '0;
            else if (r_hpos != 10'h3FF) r_hpos <= r_hpos + 10'd1;
            r_vpos   <= w_vpos_nxt;
            if (w_hfall)      r_vpend <= 1'b0;
            else if (w_vfall) r_vpend <= 1'b1;
            r_wd     <= (w_hfall || w_wd_fire) ? 10'd0 : r_wd + 10'd1;
        end
    end

    // Registered pixel outputs plus frame pulse and frame counter
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            pixel_valid <= 1'b0;
            pixel_x     <= '0;
            pixel_y     <= '0;
            pixel_rgb   <= '0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
        end else begin
            pixel_valid <= w_valid;
            pixel_x     <= w_valid ? 10'(int'(r_hpos) - HBP) : 10'd0;
            pixel_y     <= w_valid ? 9'(int'(r_vpos) - VBP) : 9'd0;
            pixel_rgb   <= w_valid ? r_rgb_s2 : 12'd0;
            frame_start <= w_vload;
            frame_cnt   <= frame_cnt + {7'd0, w_vload};
        end
    end

    logic [15:0] r_acc;

    // Per-frame pixel sum and probe capture, fed from the registered pixel
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            frame_sum <= '0;
            probe_rgb <= '0;
        end else begin
            if (frame_start) begin
                frame_sum <= r_acc;
                r_acc     <= pixel_valid ? {4'd0, pixel_rgb} : 16'd0;
            end else if (pixel_valid) begin
                r_acc     <= r_acc + {4'd0, pixel_rgb};
            end
            if (pixel_valid && pixel_x == probe_x && pixel_y == probe_y)
                probe_rgb <= pixel_rgb;
        end
    end

    // Sticky error flags; a set in the same cycle wins over err_clr
    always_ff @(posedge vga_clk or posedge rst) begin
        if (rst) begin
            err_hline  <= 1'b0;
            err_hpulse <= 1'b0;
            err_vframe <= 1'b0;
            err_nosync <= 1'b0;
        end else begin
            err_hline  <= w_hline_set  | (err_hline  & ~err_clr);
            err_hpulse <= w_hpulse_set | (err_hpulse & ~err_clr);
            err_vframe <= w_vframe_set | (err_vframe & ~err_clr);
            err_nosync <= w_wd_fire    | (err_nosync & ~err_clr);
        end
    end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Loopback bench: a behavioural VGA generator with a random static tile
// pattern drives the decoder; expectations come from the generator's timing.
module tb_vga_sync_decoder;

    localparam int GH = 20, HP = 3, HBP = 6, HFP = 18;
    localparam int GV = 10, VP = 2, VBP = 3, VFP = 9;
    localparam int NX = HFP - HBP, NY = VFP - VBP;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, h_sync, v_sync, err_clr = 1'b0;
    logic [3:0]  v_red, v_green, v_blue;
    logic [9:0]  probe_x = '0, pixel_x;
    logic [8:0]  probe_y = '0, pixel_y;
    logic        pixel_valid, frame_start, locked;
    logic [11:0] pixel_rgb, probe_rgb;
    logic [7:0]  frame_cnt;
    logic [15:0] frame_sum;
    logic        err_hline, err_hpulse, err_vframe, err_nosync;

    vga_sync_decoder #(.H_TOTAL(GH), .V_TOTAL(GV), .H_PULSE(HP), .V_PULSE(VP),
                       .HBP(HBP), .HFP(HFP), .VBP(VBP), .VFP(VFP)) dut (
        .vga_clk(clk), .rst(rst), .h_sync(h_sync), .v_sync(v_sync),
        .v_red(v_red), .v_green(v_green), .v_blue(v_blue),
        .probe_x(probe_x), .probe_y(probe_y), .err_clr(err_clr),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pixel_valid(pixel_valid), .pixel_rgb(pixel_rgb),
        .frame_start(frame_start), .locked(locked), .frame_cnt(frame_cnt),
        .frame_sum(frame_sum), .probe_rgb(probe_rgb),
        .err_hline(err_hline), .err_hpulse(err_hpulse), .err_vframe(err_vframe), .err_nosync(err_nosync));

    typedef struct packed { logic [9:0] x; logic [8:0] y; logic [11:0] rgb; } pix_t;

    int   checks = 0, errors = 0;
    int   g_h = 0, g_v = 0, g_frames = 0, g_stretch = 0, g_vpulse = VP;
    bit   g_hforce = 1'b0, g_push = 1'b0, mon_en = 1'b0;
    int   mon_cnt = 0;
    logic [11:0] tile [9];
    pix_t exp_q [$];

    function automatic logic [11:0] pat(int x, int y);
        return tile[(y / 2) * 3 + x / 4];
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Generator: advances one pixel per clock on the falling edge
    task automatic drive();
        logic        act;
        logic [11:0] c;
        act = (g_h >= HBP) && (g_h < HFP) && (g_v >= VBP) && (g_v < VFP);
        c   = act ? pat(g_h - HBP, g_v - VBP) : 12'd0;
        h_sync  = g_hforce ? 1'b1 : (g_h >= HP);
        v_sync  = (g_v >= g_vpulse);
        {v_red, v_green, v_blue} = c;
        if (act && g_push) exp_q.push_back('{x: 10'(g_h - HBP), y: 9'(g_v - VBP), rgb: c});
    endtask

    initial begin
        for (int i = 0; i < 9; i++) tile[i] = 12'($urandom);
        drive();
        forever begin
            @(negedge clk);
            if (g_h >= GH - 1 + g_stretch) begin
                g_h = 0;
                g_stretch = 0;
                if (g_v == GV - 1) begin g_v = 0; g_frames++; end
                else g_v++;
            end else begin
                g_h++;
            end
            drive();
        end
    end

    // Pixel-stream monitor against the generator's queue
    initial begin
        pix_t e;
        forever begin
            @(negedge clk); #1;
            if (mon_en) begin
                if (pixel_valid) begin
                    if (exp_q.size() == 0) chk("pix_extra", 32'(mon_cnt), 32'(NX * NY));
                    else begin
                        e = exp_q.pop_front();
                        chk("pix_x", pixel_x, e.x);
                        chk("pix_y", pixel_y, e.y);
                        chk("pix_rgb", pixel_rgb, e.rgb);
                        mon_cnt++;
                    end
                end else begin
                    chk("pix_blank", {pixel_x, pixel_y, pixel_rgb}, 0);
                end
            end
        end
    end

    task automatic tick();  @(negedge clk); #1; endtask
    task automatic ticks(input int n); for (int i = 0; i < n; i++) tick(); endtask

    task automatic wait_frames(input int n);
        for (int k = 0; k < n; k++) begin
            int start, cnt;
            start = g_frames; cnt = 0;
            while (g_frames == start && cnt < 1000) begin tick(); cnt++; end
            if (cnt >= 1000) chk("frame_timeout", 32'(g_frames), 32'(start + 1));
        end
    endtask

    task automatic wait_pos(input int v, input int h);
        int cnt;
        cnt = 0;
        while (!(g_v == v && g_h == h) && cnt < 2000) begin tick(); cnt++; end
        if (cnt >= 2000) chk("pos_timeout", 32'(g_v * 100 + g_h), 32'(v * 100 + h));
    endtask

    task automatic clear_errs();
        err_clr = 1'b1; tick(); err_clr = 1'b0; tick();
    endtask

    task automatic chk_errs(input string tag);
        chk(tag, {err_hline, err_hpulse, err_vframe, err_nosync}, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_pix", {pixel_x, pixel_y, pixel_valid, pixel_rgb}, 0);
        chk("rst_frame", {frame_start, locked, frame_cnt, frame_sum}, 0);
        chk("rst_probe_err", {probe_rgb, err_hline, err_hpulse, err_vframe, err_nosync}, 0);
    endtask

    initial begin
        logic [15:0] exp_sum;
        logic [11:0] exp_probe;
        int px, py, saw;

        exp_sum = '0;
        #1;
        for (int y = 0; y < NY; y++)
            for (int x = 0; x < NX; x++) exp_sum = exp_sum + {4'd0, pat(x, y)};

        // reset state, then release mid-frame with h_sync high
        ticks(5);
        chk_reset_vals();
        wait_pos(5, 10);
        rst = 1'b0;

        // acquisition: locked only after the second v_sync fall
        wait_frames(1); ticks(4);
        chk("lock_after_1", locked, 0);
        chk("fcnt_1", frame_cnt, 1);
        wait_frames(1); ticks(4);
        chk("lock_after_2", locked, 1);
        chk("fcnt_2", frame_cnt, 2);
        chk("fsum_1", frame_sum, exp_sum);
        chk("probe_00", probe_rgb, pat(0, 0));
        chk_errs("errs_locked");

        // one full frame of pixels against the generator
        g_push = 1'b1; mon_en = 1'b1;
        wait_frames(1); ticks(4);
        mon_en = 1'b0; g_push = 1'b0;
        chk("pix_count", 32'(mon_cnt), 32'(NX * NY));
        chk("pix_left", 32'(exp_q.size()), 0);
        chk("fsum_2", frame_sum, exp_sum);

        // probes: far corner, random points, then out-of-range ones
        probe_x = 10'(NX - 1); probe_y = 9'(NY - 1);
        wait_frames(1); ticks(4);
        chk("probe_corner", probe_rgb, pat(NX - 1, NY - 1));
        for (int i = 0; i < 3; i++) begin
            px = $urandom_range(NX - 1, 0); py = $urandom_range(NY - 1, 0);
            probe_x = 10'(px); probe_y = 9'(py);
            wait_frames(1); ticks(4);
            chk("probe_rand", probe_rgb, pat(px, py));
            chk("fsum_rand", frame_sum, exp_sum);
        end
        exp_probe = pat(px, py);
        probe_x = 10'(NX); probe_y = 9'd0;
        wait_frames(1); ticks(4);
        chk("probe_oor_x", probe_rgb, exp_probe);
        probe_x = 10'h3FF; probe_y = 9'h1FF;
        wait_frames(1); ticks(4);
        chk("probe_oor_max", probe_rgb, exp_probe);
        chk("lock_steady", locked, 1);

        // one line stretched by a clock while locked
        wait_pos(4, 5); g_stretch = 1;
        wait_pos(5, 5);
        chk("hline_set", err_hline, 1);
        chk("hline_unlock", locked, 0);
        chk("hline_other", {err_hpulse, err_vframe, err_nosync}, 0);
        clear_errs();
        chk("hline_clr", err_hline, 0);
        wait_frames(1); ticks(4);
        chk("hline_acq", locked, 0);
        wait_frames(1); ticks(4);
        chk("hline_relock", locked, 1);
        chk_errs("hline_clean");

        // three-line vsync pulse
        wait_pos(5, 0); g_vpulse = 3;
        wait_pos(2, 10);
        chk("vpulse_before", err_vframe, 0);
        wait_pos(3, 6);
        chk("vpulse_set", err_vframe, 1);
        chk("vpulse_unlock", locked, 0);
        g_vpulse = VP;
        clear_errs();
        wait_frames(2); ticks(4);
        chk("vpulse_relock", locked, 1);
        chk_errs("vpulse_clean");

        // watchdog: h_sync stuck high; set wins over a held err_clr
        wait_pos(5, 10);
        g_hforce = 1'b1; err_clr = 1'b1; saw = 0;
        for (int i = 0; i < 1300; i++) begin tick(); if (err_nosync) saw = 1; end
        chk("wd_fire_vs_clr", 32'(saw), 1);
        chk("wd_clr_held", err_nosync, 0);
        chk("wd_unlock", locked, 0);
        err_clr = 1'b0;
        ticks(1100);
        chk("wd_sticky", err_nosync, 1);
        wait_pos(5, 10); g_hforce = 1'b0;
        wait_pos(6, 5);
        clear_errs();
        chk("wd_clr", err_nosync, 0);
        wait_frames(4);
        clear_errs();
        wait_frames(2); ticks(4);
        chk("wd_relock", locked, 1);
        chk_errs("wd_clean");

        // reset mid-frame
        wait_pos(5, 10);
        rst = 1'b1; ticks(2);
        chk_reset_vals();
        tick(); rst = 1'b0;
        wait_frames(1); ticks(4);
        chk("rst2_lock_1", locked, 0);
        chk("rst2_fcnt_1", frame_cnt, 1);
        wait_frames(1); ticks(4);
        chk("rst2_lock_2", locked, 1);
        chk("rst2_fcnt_2", frame_cnt, 2);
        chk_errs("rst2_clean");

        // frame counter wrap
        wait_frames(253); ticks(4);
        chk("fcnt_255", frame_cnt, 255);
        wait_frames(1); ticks(4);
        chk("fcnt_wrap", frame_cnt, 0);
        chk("end_lock", locked, 1);
        chk("end_fsum", frame_sum, exp_sum);
        chk_errs("end_clean");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
